// File: rtl/line_mem_responder.sv
// Single-outstanding line memory slave: 128-bit lines behind separate read/write
// address, data and response handshakes, with a fixed read latency.
module line_mem_responder #(
  parameter int DEPTH_LINES = 4096,
  parameter int RD_LATENCY  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  readAddr_addr,
  input  logic         readAddr_valid,
  output logic         readAddr_ready,
  output logic [127:0] readData_data,
  output logic         readData_valid,
  input  logic         readData_ready,
  input  logic [31:0]  writeAddr_addr,
  input  logic         writeAddr_valid,
  output logic         writeAddr_ready,
  input  logic [127:0] writeData_data,
  input  logic [15:0]  writeData_strb,
  input  logic         writeData_valid,
  output logic         writeData_ready,
  output logic [31:0]  writeResp_msg,
  output logic         writeResp_valid,
  input  logic         writeResp_ready
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;

  state_t         r_state;
  logic [3:0]     r_cnt;
  logic [27:0]    r_rd_addr;
  logic [27:0]    r_wr_addr;
  logic [127:0]   r_rdata;
  logic [31:0]    r_msg;
  logic [127:0]   r_mem [DEPTH_LINES];

  logic           w_rd_acc, w_wr_acc, w_wd_acc, w_ld_rdata, w_we;
  logic [27:0]    w_rsrc;
  logic           w_unused;

  // Address bits [3:0] select a byte within the line and play no part in decode.
  function automatic logic f_oor(input logic [27:0] a);
    return (a[27:12] != 16'd0) || ({20'd0, a[11:0]} >= 32'(DEPTH_LINES));
  endfunction

  assign w_unused        = ^{readAddr_addr[3:0], writeAddr_addr[3:0]};

  assign readAddr_ready  = !rst && (r_state == IDLE);
  assign writeAddr_ready = !rst && (r_state == IDLE) && !readAddr_valid;
  assign writeData_ready = !rst && (r_state == WR_DATA);
  assign readData_valid  = !rst && (r_state == RD_DATA);
  assign writeResp_valid = !rst && (r_state == WR_RESP);
  assign readData_data   = readData_valid  ? r_rdata : '0;
  assign writeResp_msg   = writeResp_valid ? r_msg   : '0;

  assign w_rd_acc   = readAddr_valid  && readAddr_ready;
  assign w_wr_acc   = writeAddr_valid && writeAddr_ready;
  assign w_wd_acc   = writeData_valid && writeData_ready;
  // With zero latency the line is fetched straight from the incoming address.
  assign w_rsrc     = (r_state == IDLE) ? readAddr_addr[31:4] : r_rd_addr;
  assign w_ld_rdata = (w_rd_acc && (RD_LATENCY == 0)) ||
                      ((r_state == RD_WAIT) && (r_cnt <= 4'd1));
  assign w_we       = w_wd_acc && !f_oor(r_wr_addr);

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 16; b++) begin
        if (writeData_strb[b]) r_mem[r_wr_addr[11:0]][8*b +: 8] <= writeData_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_rdata   <= '0;
      r_msg     <= '0;
    end else begin
      if (w_ld_rdata) r_rdata <= f_oor(w_rsrc) ? '0 : r_mem[w_rsrc[11:0]];
      case (r_state)
        IDLE: begin
          if (w_rd_acc) begin
            r_rd_addr <= readAddr_addr[31:4];
            r_cnt     <= 4'(RD_LATENCY);
            r_state   <= (RD_LATENCY == 0) ? RD_DATA : RD_WAIT;
          end else if (w_wr_acc) begin
            r_wr_addr <= writeAddr_addr[31:4];
            r_state   <= WR_DATA;
          end
        end
        RD_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= RD_DATA;
        end
        RD_DATA: begin
          if (readData_ready) begin
            r_rdata <= '0;
            r_state <= IDLE;
          end
        end
        WR_DATA: begin
          if (writeData_valid) begin
            r_msg   <= f_oor(r_wr_addr) ? 32'h2 : 32'h0;
            r_state <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (writeResp_ready) begin
            r_msg   <= '0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
